// File: rtl/vec_operand_loader.sv
// vec_operand_loader: packs C serial (x, k) pairs into parallel operand buses,
// runs the multiplier, and hands its truncated result downstream.
//   clk, rst          clock, asynchronous active-high reset
//   s_valid/s_ready   upstream element handshake carrying s_x, s_k
//   mul_enable        multiplier enable; mul_x/mul_k packed operands (slot i at [i*W +: W])
//   mul_y/mul_valid   multiplier result and its valid pulse
//   m_valid/m_ready   downstream handshake carrying m_y and m_err
//   busy              high outside LOAD
// Optional: define VEC_LOADER_TIMEOUT_EN to abandon RUN after TIMEOUT cycles
// without mul_valid (result m_y=0, m_err=1).
module vec_operand_loader #(
    parameter int C       = 8,
    parameter int W_X     = 8,
    parameter int W_K     = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_X-1:0]   s_x,
    input  logic [W_K-1:0]   s_k,
    output logic             mul_enable,
    output logic [C*W_X-1:0] mul_x,
    output logic [C*W_K-1:0] mul_k,
    input  logic [W_X-1:0]   mul_y,
    input  logic             mul_valid,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W_X-1:0]   m_y,
    output logic             m_err,
    output logic             busy
);
    localparam int IW = $clog2(C);
    typedef enum logic [1:0] {LOAD, RUN, OUT} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx;
    logic expired;
`ifdef VEC_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;
    assign expired = cnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt   <= '0;
            m_err <= 1'b0;
        end else begin
            cnt <= state == RUN ? cnt + TW'(1) : '0;
            if (state == RUN && !mul_valid && expired)
                m_err <= 1'b1;
            else if (state == OUT && m_ready)
                m_err <= 1'b0;
        end
`else
    assign expired = 1'b0;
    assign m_err   = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= LOAD;
            idx   <= '0;
            mul_x <= '0;
            mul_k <= '0;
            m_y   <= '0;
        end else begin
            state <= state_n;
            if (state == LOAD && s_valid) begin
                mul_x[idx*W_X +: W_X] <= s_x;
                mul_k[idx*W_K +: W_K] <= s_k;
                idx <= idx == IW'(C - 1) ? '0 : idx + IW'(1);
            end
            // mul_valid wins over a same-cycle timeout
            if (state == RUN && (mul_valid || expired))
                m_y <= mul_valid ? mul_y : '0;
        end
    always_comb begin
        state_n    = state;
        s_ready    = state == LOAD;
        mul_enable = state == RUN;
        m_valid    = state == OUT;
        busy       = state != LOAD;
        state_n    = state == LOAD ? ((s_valid && idx == IW'(C - 1)) ? RUN : LOAD)
                   : state == RUN  ? ((mul_valid || expired) ? OUT : RUN)
                   : (m_ready ? LOAD : OUT);
    end
endmodule

// File: tb/tb_vec_operand_loader.sv
// tb_vec_operand_loader: scoreboard bench for vec_operand_loader with a latency-3 multiplier model.
module tb_vec_operand_loader;
    logic        clk = 0, rst = 1;
    logic        s_valid = 0, s_ready;
    logic [7:0]  s_x = 0, s_k = 0;
    logic        mul_enable, mul_valid;
    logic [63:0] mul_x, mul_k;
    logic [7:0]  mul_y;
    logic        m_valid, m_ready = 0, m_err, busy;
    logic [7:0]  m_y;
    logic        mul_off = 0;
    int          mcnt = 0;
    int          checks = 0, errors = 0;
    typedef struct {logic [7:0] y; logic err;} exp_t;
    exp_t        q[$];

    vec_operand_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_k(s_k),
        .mul_enable(mul_enable), .mul_x(mul_x), .mul_k(mul_k), .mul_y(mul_y),
        .mul_valid(mul_valid), .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y),
        .m_err(m_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mcnt <= mul_enable ? mcnt + 1 : 0;
    assign mul_valid = mul_enable && mcnt == 2 && !mul_off;
    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) s += $signed(mul_x[i*8 +: 8]) * $signed(mul_k[i*8 +: 8]);
        mul_y = s[7:0];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_vec(input logic [63:0] xv, input logic [63:0] kv, input logic err);
        int   s;
        exp_t e;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            s += $signed(xv[i*8 +: 8]) * $signed(kv[i*8 +: 8]);
            s_valid = 1; s_x = xv[i*8 +: 8]; s_k = kv[i*8 +: 8];
            @(negedge clk);
        end
        s_valid = 0;
        e.y = err ? 8'h00 : s[7:0];
        e.err = err;
        q.push_back(e);
        chk("mul_x_packed", mul_x, xv);
        chk("mul_k_packed", mul_k, kv);
    endtask

    task automatic wait_result(input int budget, input int en_exp);
        int   n, en;
        exp_t e;
        n = 0; en = 0;
        while (!m_valid && n < budget) begin
            if (mul_enable) en++;
            @(negedge clk);
            n++;
        end
        chk("m_valid_seen", m_valid, 1);
        chk("enable_cycles", en, en_exp);
        chk("mul_enable_out", mul_enable, 0);
        if (m_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("m_y", m_y, e.y);
            chk("m_err", m_err, e.err);
        end
    endtask

    task automatic release_out();
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
        chk("back_to_load_ready", s_ready, 1);
        chk("back_to_load_busy", busy, 0);
    endtask

    initial begin
        logic [63:0] xv, kv;
        logic [7:0]  y0;
        int          seen;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mul_enable", mul_enable, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_y", m_y, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_mul_x", mul_x, 0);
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin xv[i*8 +: 8] = 8'(i + 1); kv[i*8 +: 8] = 8'd1; end
        send_vec(xv, kv, 0);
        wait_result(40, 3);
        chk("m_y_36", m_y, 8'h24);
        release_out();
        send_vec({8{8'hFF}}, {8{8'h02}}, 0);
        wait_result(40, 3);
        chk("m_y_neg16", m_y, 8'hF0);
        release_out();
        send_vec({8{8'h7F}}, {8{8'h7F}}, 0);
        wait_result(40, 3);
        chk("m_y_trunc", m_y, 8'h08);
        y0 = m_y;
        s_valid = 1; s_x = 8'h55; s_k = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_y", m_y, y0);
            chk("stall_m_err", m_err, 0);
            chk("stall_s_ready", s_ready, 0);
            chk("stall_mul_enable", mul_enable, 0);
        end
        s_valid = 0;
        release_out();
        send_vec({8{8'h09}}, {8{8'h09}}, 0);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("midrst_mul_enable", mul_enable, 0);
        chk("midrst_mul_x", mul_x, 0);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_m_valid", m_valid, 0);
        void'(q.pop_back());
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        send_vec({8{8'h02}}, {8{8'h03}}, 0);
        wait_result(40, 3);
        chk("m_y_48", m_y, 8'h30);
        release_out();
        mul_off = 1;
`ifdef VEC_LOADER_TIMEOUT_EN
        send_vec({8{8'h01}}, {8{8'h01}}, 1);
        wait_result(60, 16);
        release_out();
        chk("m_err_cleared", m_err, 0);
`else
        send_vec({8{8'h01}}, {8{8'h01}}, 0);
        void'(q.pop_back());
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        chk("no_timeout_m_valid", seen, 0);
        chk("no_timeout_enable", mul_enable, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
